// File: rtl/calc2_sched_pkg.sv
// Shared types for the calc2 request scheduler: command/response codes, tag type, issue FSM states.
package calc2_sched_pkg;

  localparam int NUM_TAGS = 4;

  typedef logic [1:0] tag_t;

  typedef enum logic [3:0] {
    CMD_NOP = 4'd0,
    CMD_ADD = 4'd1,
    CMD_SUB = 4'd2,
    CMD_SHL = 4'd5,
    CMD_SHR = 4'd6
  } cmd_e;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_OK   = 2'd1,
    RESP_OVF  = 2'd2,
    RESP_TMO  = 2'd3
  } resp_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OP1  = 2'd1,
    ST_OP2  = 2'd2
  } state_e;

endpackage

// File: rtl/calc2_tag_pool.sv
// Tag free-list: hands out the lowest free tag, frees on pop; a tag freed at an edge is
// only offered again from the next cycle because the allocator looks at registered state.
module calc2_tag_pool
  import calc2_sched_pkg::*;
(
  input  logic                c_clk,
  input  logic                reset,
  input  logic                alloc_i,
  output logic [1:0]          alloc_tag_o,
  input  logic                free_i,
  input  logic [1:0]          free_tag_i,
  output logic [NUM_TAGS-1:0] busy_o,
  output logic [2:0]          count_o
);

  logic [NUM_TAGS-1:0] busy_q, busy_d;
  logic [2:0]          count_q, count_d;

  always_comb begin
    alloc_tag_o = 2'd0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (!busy_q[i]) alloc_tag_o = 2'(i);
    end
  end

  always_comb begin
    busy_d  = busy_q;
    count_d = count_q;
    if (free_i)  busy_d[free_tag_i]  = 1'b0;
    if (alloc_i) busy_d[alloc_tag_o] = 1'b1;
    if (alloc_i && !free_i)      count_d = count_q + 3'd1;
    else if (!alloc_i && free_i) count_d = count_q - 3'd1;
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      busy_q  <= '0;
      count_q <= 3'd0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign busy_o  = busy_q;
  assign count_o = count_q;

endmodule

// File: rtl/calc2_req_sched.sv
// Two-beat calc2 request issuer with 4 tags; results leave in acceptance order once the head tag is done.
// Optional per-tag response timeout under CALC2_SCHED_TIMEOUT_EN; in_ready drops in OP1 and when all tags are in use.
module calc2_req_sched
  import calc2_sched_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_cmd,
  input  logic [31:0] in_op1,
  input  logic [31:0] in_op2,
  output logic [3:0]  req_cmd_out,
  output logic [31:0] req_data_out,
  output logic [1:0]  req_tag_out,
  input  logic [1:0]  resp_in,
  input  logic [31:0] data_in,
  input  logic [1:0]  tag_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  out_resp,
  output logic [31:0] out_data,
  output logic [2:0]  outstanding,
  output logic        protocol_err
);

  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 2");
  end

  state_e              state_q, state_d;
  logic                rdy_en_q;
  logic [3:0]          cmd_q;
  logic [31:0]         op1_q, op2_q;
  tag_t                tag_q;
  tag_t                fifo_q [NUM_TAGS];
  tag_t                wr_ptr_q, rd_ptr_q;
  logic [NUM_TAGS-1:0] done_q, done_d;
  logic [1:0]          resp_st_q [NUM_TAGS];
  logic [31:0]         data_st_q [NUM_TAGS];
  logic                perr_q;

  logic                accept, pop, rsp_vld, rsp_hit;
  tag_t                alloc_tag, head_tag;
  logic [NUM_TAGS-1:0] busy, tmo_fire;
  logic [2:0]          tag_cnt;

  calc2_tag_pool u_pool (
    .c_clk       (c_clk),
    .reset       (reset),
    .alloc_i     (accept),
    .alloc_tag_o (alloc_tag),
    .free_i      (pop),
    .free_tag_i  (head_tag),
    .busy_o      (busy),
    .count_o     (tag_cnt)
  );

  assign accept       = in_valid && in_ready;
  assign pop          = out_valid && out_ready;
  assign head_tag     = fifo_q[rd_ptr_q];
  assign rsp_vld      = (resp_in != 2'd0);
  assign rsp_hit      = rsp_vld && busy[tag_in] && !done_q[tag_in];
  assign outstanding  = tag_cnt;
  assign out_valid    = (tag_cnt != 3'd0) && done_q[head_tag];
  assign out_resp     = out_valid ? resp_st_q[head_tag] : 2'd0;
  assign out_data     = out_valid ? data_st_q[head_tag] : 32'd0;
  assign protocol_err = perr_q;

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_OP1;
      ST_OP1:  state_d = ST_OP2;
      ST_OP2:  state_d = accept ? ST_OP1 : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // rdy_en_q holds in_ready low for the first cycle after reset release.
  always_comb begin
    in_ready     = rdy_en_q && (state_q != ST_OP1) && (tag_cnt < 3'(NUM_TAGS));
    req_cmd_out  = 4'd0;
    req_data_out = 32'd0;
    req_tag_out  = 2'd0;
    case (state_q)
      ST_OP1: begin
        req_cmd_out  = cmd_q;
        req_data_out = op1_q;
        req_tag_out  = tag_q;
      end
      ST_OP2: begin
        req_data_out = op2_q;
        req_tag_out  = tag_q;
      end
      default: ;
    endcase
  end

  // Pop and response never target the same tag: the head is already done, a hit requires not-done.
  always_comb begin
    done_d = done_q;
    if (pop)     done_d[head_tag] = 1'b0;
    if (rsp_hit) done_d[tag_in]   = 1'b1;
    done_d = done_d | tmo_fire;
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      rdy_en_q <= 1'b0;
      cmd_q    <= 4'd0;
      op1_q    <= 32'd0;
      op2_q    <= 32'd0;
      tag_q    <= 2'd0;
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      done_q   <= '0;
      perr_q   <= 1'b0;
      for (int i = 0; i < NUM_TAGS; i++) begin
        fifo_q[i]    <= 2'd0;
        resp_st_q[i] <= 2'd0;
        data_st_q[i] <= 32'd0;
      end
    end else begin
      rdy_en_q <= 1'b1;
      done_q   <= done_d;
      if (accept) begin
        cmd_q            <= in_cmd;
        op1_q            <= in_op1;
        op2_q            <= in_op2;
        tag_q            <= alloc_tag;
        fifo_q[wr_ptr_q] <= alloc_tag;
        wr_ptr_q         <= wr_ptr_q + 2'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
      if (rsp_vld && !rsp_hit) perr_q <= 1'b1;
      if (rsp_hit) begin
        resp_st_q[tag_in] <= resp_in;
        data_st_q[tag_in] <= data_in;
      end
      for (int i = 0; i < NUM_TAGS; i++) begin
        if (tmo_fire[i]) begin
          resp_st_q[i] <= RESP_TMO;
          data_st_q[i] <= 32'd0;
        end
      end
    end
  end

`ifdef CALC2_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0]       tmo_cnt_q [NUM_TAGS];
  logic [NUM_TAGS-1:0] tmo_run_q, rsp_mask;

  // A real response in the same cycle as the timeout wins.
  always_comb begin
    rsp_mask = '0;
    tmo_fire = '0;
    if (rsp_hit) rsp_mask[tag_in] = 1'b1;
    for (int i = 0; i < NUM_TAGS; i++) begin
      tmo_fire[i] = tmo_run_q[i] && !rsp_mask[i] && (tmo_cnt_q[i] == CW'(TIMEOUT_CYC - 1));
    end
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      tmo_run_q <= '0;
      for (int i = 0; i < NUM_TAGS; i++) tmo_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_TAGS; i++) begin
        if (state_q == ST_OP2 && tag_q == 2'(i) && !done_q[i] && !rsp_mask[i]) begin
          tmo_run_q[i] <= 1'b1;
          tmo_cnt_q[i] <= CW'(1);
        end else if (tmo_run_q[i] && (tmo_fire[i] || rsp_mask[i])) begin
          tmo_run_q[i] <= 1'b0;
        end else if (tmo_run_q[i]) begin
          tmo_cnt_q[i] <= tmo_cnt_q[i] + CW'(1);
        end
      end
    end
  end
`else
  assign tmo_fire = '0;
`endif

endmodule
